// File: rtl/conv_accum_if.sv
// Bundle of the stream, memory and status signals of conv_accum_stage.
// slave is the stage side; master is the surrounding core/memory/sink side.
interface conv_accum_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 4
);
    logic                 bypass;
    logic [DataWidth-1:0] conv_in;
    logic                 conv_valid;
    logic                 accum_request;
    logic [DataWidth-1:0] accum_in;
    logic                 accum_valid;
    logic [DataWidth-1:0] result_out;
    logic                 result_valid;
    logic                 result_ready;
    logic [AddrWidth:0]   fifo_count;
    logic                 overflow_err;
    logic                 protocol_err;
    logic                 sat_flag;

    modport slave (
        input  bypass, conv_in, conv_valid, accum_in, accum_valid, result_ready,
        output accum_request, result_out, result_valid, fifo_count,
               overflow_err, protocol_err, sat_flag
    );

    modport master (
        output bypass, conv_in, conv_valid, accum_in, accum_valid, result_ready,
        input  accum_request, result_out, result_valid, fifo_count,
               overflow_err, protocol_err, sat_flag
    );
endinterface

// File: rtl/conv_accum_stage.sv
// Partial-sum accumulation stage: buffers conv results, fetches matching partial
// sums from memory, adds them (optionally saturating) or bypasses, with backpressure.
module conv_accum_stage #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 16,
    parameter int unsigned AddrWidth = 4,
    parameter int unsigned Saturate  = 1
) (
    input logic        clk,
    input logic        rst,
    conv_accum_if.slave bus
);
    localparam int unsigned CountWidth = AddrWidth + 1;
    localparam int unsigned SumWidth   = DataWidth + 1;
    localparam bit          SatEn      = (Saturate != 0);

    logic [DataWidth-1:0]  mem [FifoDepth];
    logic [AddrWidth-1:0]  wr_ptr;
    logic [AddrWidth-1:0]  rd_ptr;
    logic [CountWidth-1:0] count;
    logic [DataWidth-1:0]  result_q;
    logic                  result_valid_q;
    logic                  overflow_q;
    logic                  protocol_q;
    logic                  sat_q;

    logic                  nonempty;
    logic                  full;
    logic                  free;
    logic                  request;
    logic                  pop;
    logic                  push;
    logic                  sum_ovf;
    logic [DataWidth-1:0]  head;
    logic [SumWidth-1:0]   sum_full;
    logic [DataWidth-1:0]  add_result;
    logic [DataWidth-1:0]  pop_value;

    assign head     = mem[rd_ptr];
    assign nonempty = (count != '0);
    assign full     = (count == CountWidth'(FifoDepth));
    assign free     = !result_valid_q || bus.result_ready;
    assign request  = !bus.bypass && nonempty && free;
    assign pop      = bus.bypass ? (nonempty && free) : (bus.accum_valid && request);
    assign push     = bus.conv_valid && (!full || pop);

    // Sign-extended add; overflow shows as disagreement of the top two sum bits.
    assign sum_full = {head[DataWidth-1], head} + {bus.accum_in[DataWidth-1], bus.accum_in};
    assign sum_ovf  = sum_full[DataWidth] ^ sum_full[DataWidth-1];

    always_comb begin
        add_result = sum_full[DataWidth-1:0];
        if (SatEn && sum_ovf) begin
            add_result = sum_full[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                             : {1'b0, {(DataWidth-1){1'b1}}};
        end
        pop_value = bus.bypass ? head : add_result;
    end

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.conv_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AddrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AddrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (pop) begin
            result_q       <= pop_value;
            result_valid_q <= 1'b1;
        end else if (result_valid_q && bus.result_ready) begin
            result_valid_q <= 1'b0;
        end
    end

    // Sticky error and saturation flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            protocol_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            if (bus.conv_valid && !push) begin
                overflow_q <= 1'b1;
            end
            if (bus.accum_valid && !request) begin
                protocol_q <= 1'b1;
            end
            if (SatEn && pop && !bus.bypass && sum_ovf) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign bus.accum_request = request;
    assign bus.result_out    = result_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.fifo_count    = count;
    assign bus.overflow_err  = overflow_q;
    assign bus.protocol_err  = protocol_q;
    assign bus.sat_flag      = sat_q;
endmodule

// File: tb/tb_conv_accum_stage.sv
// Directed bench for conv_accum_stage: a saturating depth-4 instance plus a
// wrapping instance used for the modulo-arithmetic cases.
module tb_conv_accum_stage;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned FD = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    conv_accum_if #(.DataWidth(DW), .AddrWidth(AW)) b ();
    conv_accum_if #(.DataWidth(DW), .AddrWidth(AW)) w ();

    conv_accum_stage #(.DataWidth(DW), .FifoDepth(FD), .AddrWidth(AW), .Saturate(1)) u_sat (
        .clk(clk), .rst(rst), .bus(b.slave)
    );
    conv_accum_stage #(.DataWidth(DW), .FifoDepth(FD), .AddrWidth(AW), .Saturate(0)) u_wrap (
        .clk(clk), .rst(rst), .bus(w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        b.bypass = 1'b0; b.conv_in = '0; b.conv_valid = 1'b0;
        b.accum_in = '0; b.accum_valid = 1'b0; b.result_ready = 1'b1;
        w.bypass = 1'b0; w.conv_in = '0; w.conv_valid = 1'b0;
        w.accum_in = '0; w.accum_valid = 1'b0; w.result_ready = 1'b1;
        #2;
        check("rst_count", 64'(b.fifo_count), 64'd0);
        check("rst_valid", 64'(b.result_valid), 64'd0);
        check("rst_out", 64'(b.result_out), 64'd0);
        check("rst_req", 64'(b.accum_request), 64'd0);
        check("rst_flags", 64'({b.overflow_err, b.protocol_err, b.sat_flag}), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Bypass stream 5,6,7
        b.bypass = 1'b1;
        b.conv_valid = 1'b1; b.conv_in = 32'd5;
        tick();
        b.conv_in = 32'd6;
        check("byp_req0", 64'(b.accum_request), 64'd0);
        check("byp_lat1_valid", 64'(b.result_valid), 64'd0);
        tick();
        check("byp_out5", 64'(b.result_out), 64'd5);
        check("byp_valid5", 64'(b.result_valid), 64'd1);
        b.conv_in = 32'd7;
        tick();
        check("byp_out6", 64'(b.result_out), 64'd6);
        check("byp_req1", 64'(b.accum_request), 64'd0);
        b.conv_valid = 1'b0;
        tick();
        check("byp_out7", 64'(b.result_out), 64'd7);
        tick();
        check("byp_drain_valid", 64'(b.result_valid), 64'd0);
        check("byp_drain_count", 64'(b.fifo_count), 64'd0);

        // Accumulate 100 + (-30)
        b.bypass = 1'b0;
        b.conv_valid = 1'b1; b.conv_in = 32'd100;
        tick();
        b.conv_valid = 1'b0;
        check("acc_count1", 64'(b.fifo_count), 64'd1);
        check("acc_req1", 64'(b.accum_request), 64'd1);
        tick();
        tick();
        b.accum_valid = 1'b1; b.accum_in = 32'hFFFF_FFE2;
        tick();
        b.accum_valid = 1'b0;
        check("acc_out70", 64'(b.result_out), 64'd70);
        check("acc_valid", 64'(b.result_valid), 64'd1);
        check("acc_count0", 64'(b.fifo_count), 64'd0);
        tick();
        check("acc_valid_clear", 64'(b.result_valid), 64'd0);

        // Positive overflow on both instances
        b.conv_valid = 1'b1; b.conv_in = 32'h7FFF_FFF0;
        w.conv_valid = 1'b1; w.conv_in = 32'h7FFF_FFF0;
        tick();
        b.conv_valid = 1'b0; w.conv_valid = 1'b0;
        b.accum_valid = 1'b1; b.accum_in = 32'h0000_0020;
        w.accum_valid = 1'b1; w.accum_in = 32'h0000_0020;
        tick();
        b.accum_valid = 1'b0; w.accum_valid = 1'b0;
        check("sat_pos_out", 64'(b.result_out), 64'h7FFF_FFFF);
        check("sat_pos_flag", 64'(b.sat_flag), 64'd1);
        check("wrap_pos_out", 64'(w.result_out), 64'h8000_0010);
        check("wrap_pos_flag", 64'(w.sat_flag), 64'd0);
        tick();

        // Negative overflow: 0x80000000 + (-1)
        b.conv_valid = 1'b1; b.conv_in = 32'h8000_0000;
        w.conv_valid = 1'b1; w.conv_in = 32'h8000_0000;
        tick();
        b.conv_valid = 1'b0; w.conv_valid = 1'b0;
        b.accum_valid = 1'b1; b.accum_in = 32'hFFFF_FFFF;
        w.accum_valid = 1'b1; w.accum_in = 32'hFFFF_FFFF;
        tick();
        b.accum_valid = 1'b0; w.accum_valid = 1'b0;
        check("sat_neg_out", 64'(b.result_out), 64'h8000_0000);
        check("wrap_neg_out", 64'(w.result_out), 64'h7FFF_FFFF);
        check("wrap_neg_flag", 64'(w.sat_flag), 64'd0);
        tick();

        // Fill to depth 4, fifth push dropped
        check("ovf_pre", 64'(b.overflow_err), 64'd0);
        b.conv_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b.conv_in = 32'(11 + i);
            tick();
        end
        check("full_count", 64'(b.fifo_count), 64'd4);
        check("ovf_flag", 64'(b.overflow_err), 64'd1);
        b.conv_in = 32'd16;
        b.accum_valid = 1'b1; b.accum_in = 32'd0;
        tick();
        b.conv_valid = 1'b0;
        check("full_pushpop_count", 64'(b.fifo_count), 64'd4);
        check("pop_11", 64'(b.result_out), 64'd11);
        tick();
        check("pop_12", 64'(b.result_out), 64'd12);
        tick();
        check("pop_13", 64'(b.result_out), 64'd13);
        tick();
        check("pop_14", 64'(b.result_out), 64'd14);
        tick();
        b.accum_valid = 1'b0;
        check("pop_16", 64'(b.result_out), 64'd16);
        check("pop_empty", 64'(b.fifo_count), 64'd0);
        check("proto_pre", 64'(b.protocol_err), 64'd0);

        // Backpressure with held result 16
        b.result_ready = 1'b0;
        b.conv_valid = 1'b1; b.conv_in = 32'd40;
        tick();
        b.conv_in = 32'd41;
        tick();
        b.conv_valid = 1'b0;
        check("bp_req", 64'(b.accum_request), 64'd0);
        check("bp_count", 64'(b.fifo_count), 64'd2);
        b.accum_valid = 1'b1; b.accum_in = 32'd5;
        tick();
        b.accum_valid = 1'b0;
        check("bp_proto", 64'(b.protocol_err), 64'd1);
        check("bp_hold_out", 64'(b.result_out), 64'd16);
        check("bp_hold_count", 64'(b.fifo_count), 64'd2);
        b.result_ready = 1'b1;
        #1;
        check("bp_req_release", 64'(b.accum_request), 64'd1);
        b.accum_valid = 1'b1; b.accum_in = 32'd1;
        tick();
        b.accum_valid = 1'b0;
        check("bp_out41", 64'(b.result_out), 64'd41);
        check("bp_count1", 64'(b.fifo_count), 64'd1);

        // Build count=3 with a held result, then reset between edges
        b.result_ready = 1'b0;
        b.conv_valid = 1'b1; b.conv_in = 32'd50;
        tick();
        b.conv_in = 32'd51;
        tick();
        b.conv_valid = 1'b0;
        check("pre_rst_count", 64'(b.fifo_count), 64'd3);
        check("pre_rst_valid", 64'(b.result_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(b.fifo_count), 64'd0);
        check("arst_valid", 64'(b.result_valid), 64'd0);
        check("arst_out", 64'(b.result_out), 64'd0);
        check("arst_req", 64'(b.accum_request), 64'd0);
        check("arst_flags", 64'({b.overflow_err, b.protocol_err, b.sat_flag}), 64'd0);
        #2;
        rst = 1'b0;
        tick();

        // After reset the FIFO starts clean
        b.result_ready = 1'b1;
        b.bypass = 1'b1;
        b.conv_valid = 1'b1; b.conv_in = 32'd9;
        tick();
        b.conv_valid = 1'b0;
        tick();
        check("post_rst_out", 64'(b.result_out), 64'd9);
        check("post_rst_count", 64'(b.fifo_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_accum_stage.md
Name: conv_accum_stage

Overview:
- Parametrised partial-sum accumulation stage placed after the multi-channel convolution core.
- Buffers a stream of convolution results in an internal FIFO of configurable depth, then requests matching partial sums from external memory.
- Adds each partial sum to the oldest buffered result in signed fixed point, with optional saturation.
- Adds over the previous generation: a bypass mode (first channel group, no partial sum fetch), downstream valid/ready backpressure, occupancy reporting, and sticky error flags.

Parameters:
- DataWidth, 32, width of conv result, partial sum and output (signed two's complement).
- FifoDepth, 16, number of buffered conv results; power of two, minimum 2.
- AddrWidth, 4, log2(FifoDepth).
- Saturate, 1, 1 = clamp on overflow; 0 = wrap modulo 2^DataWidth.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  reset, asynchronous and active-high.
- bypass  in  1  1 = forward conv result unchanged; 0 = add partial sum. Sampled at each pop.
- conv_in  in  DataWidth  convolution result.
- conv_valid  in  1  conv_in valid. No ready: the upstream core never stalls.
- accum_request  out  1  level; partial sum wanted for the FIFO head.
- accum_in  in  DataWidth  partial sum from memory.
- accum_valid  in  1  accum_in valid; legal only in a cycle where accum_request=1.
- result_out  out  DataWidth  accumulated or bypassed result.
- result_valid  out  1  result_out valid.
- result_ready  in  1  downstream accepts result_out.
- fifo_count  out  AddrWidth+1  current FIFO occupancy, 0..FifoDepth.
- overflow_err  out  1  sticky; a push arrived while full and was dropped.
- protocol_err  out  1  sticky; accum_valid arrived while accum_request=0 and was dropped.
- sat_flag  out  1  sticky; an add saturated (always 0 when Saturate=0).

Behaviour:
- Reset (asynchronous, immediate): FIFO empty, fifo_count=0, result_valid=0, result_out=0, accum_request=0, all flags 0. Reset mid-operation discards FIFO contents and any held result.
- FIFO:
  - Register array with write and read pointers of AddrWidth bits; pointers wrap modulo FifoDepth.
  - Head is read combinationally from the array.
  - push = conv_valid & (count<FifoDepth | pop).
  - conv_valid & full & !pop: the data is dropped, overflow_err is set, and count is unchanged.
  - push and pop in the same cycle leave count unchanged.
  - No fall-through: a push at edge t is visible at the head from cycle t+1.
- Output slot: free = !result_valid | result_ready.
- accum_request = !bypass & count!=0 & free. Combinational from registered state plus bypass and result_ready.
- Pop conditions:
  - Accumulate mode: accum_valid & accum_request.
  - Bypass mode: bypass & count!=0 & free.
- On pop at edge t:
  - result_out <= head + accum_in (accumulate mode) or head (bypass mode).
  - result_valid <= 1 at t+1. Latency from accum_valid to result_valid is 1 cycle.
- Minimum latency from conv_valid to result_valid:
  - Bypass mode: 2 cycles.
  - Accumulate mode: 2 cycles plus memory response time.
- result_valid & result_ready & no pop: result_valid <= 0.
- Held output: while result_valid=1 and result_ready=0, result_out is stable and no pop occurs.
- accum_valid while accum_request=0: accum_in is ignored, protocol_err is set, and the FIFO is untouched.
- Arithmetic:
  - Full-width signed sum computed in DataWidth+1 bits.
  - If Saturate=1 and the sum exceeds the range, clamp to 2^(DataWidth-1)-1 or -2^(DataWidth-1) and set sat_flag.
  - If Saturate=0, the low DataWidth bits are taken.
- Throughput: one result per cycle sustained when the memory answers in the same cycle as the request and result_ready=1.
- Changing bypass with a non-empty FIFO is legal; the new mode applies to the next pop only.

Test Plan:
- Bypass stream: bypass=1, result_ready=1, push 5,6,7 on consecutive cycles.
  - Required: result_out 5,6,7 on consecutive cycles, first one 2 cycles after the first push.
  - Required: accum_request stays 0 throughout.
- Accumulate: bypass=0, push 100, then answer the request 3 cycles later with accum_in=-30.
  - Required: result_out=70 one cycle after accum_valid; fifo_count returns 1 to 0.
- Saturation, DataWidth=32, Saturate=1: head=0x7FFFFFF0, accum_in=0x20.
  - Required: result_out=0x7FFFFFFF and sat_flag=1.
  - Same case with Saturate=0: result_out=0x80000010 and sat_flag=0.
- Full/overflow, FifoDepth=4, no accum_valid: push 5 values.
  - Required: fifo_count=4 and overflow_err=1.
  - Then a push at full in the same cycle as a pop is accepted and fifo_count stays 4.
  - Values later popped are the first 4 pushed, in order.
- Backpressure: result_ready=0 with a valid result held and the FIFO non-empty.
  - Required: accum_request=0 and result_out stable.
  - Injected accum_valid is dropped and sets protocol_err.
  - Raising result_ready re-asserts accum_request in the same cycle.
- Async reset mid-stream: Rst asserted between clock edges with fifo_count=3 and result_valid=1.
  - Required: all outputs and counts go to 0 immediately, without waiting for a clock edge.
